bus_mem_responder: RTL

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_if.sv | 22 ++
 rtl/bus_mem_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/bus_mem_responder_if.sv
// Request/response bundle between a bus initiator and the memory responder.
// Initiator holds rd/wr until it sees the matching one-cycle valid pulse.
interface bus_mem_responder_if;
  logic        i_bus_rd;
  logic        i_bus_wr;
  logic [31:0] i_bus_addr;
  logic [3:0]  i_bus_wrmask;
  logic [31:0] i_bus_data;
  logic        o_bus_rd_valid;
  logic        o_bus_wr_valid;
  logic [31:0] o_bus_data;

  modport master (
    output i_bus_rd, i_bus_wr, i_bus_addr, i_bus_wrmask, i_bus_data,
    input  o_bus_rd_valid, o_bus_wr_valid, o_bus_data
  );

  modport slave (
    input  i_bus_rd, i_bus_wr, i_bus_addr, i_bus_wrmask, i_bus_data,
    output o_bus_rd_valid, o_bus_wr_valid, o_bus_data
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-addressed memory behind a hold-until-response bus; response pulse LATENCY cycles after accept.
// No backpressure: dropping the request while waiting aborts it; read wins over a simultaneous write.
module bus_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_mem_responder_if.slave bus
);
  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_rd_q, is_rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  mask_q, mask_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req_held;
  logic [32:0]   off;
  logic          in_range;
  logic [AW-1:0] widx;

  assign req_held = is_rd_q ? bus.i_bus_rd : bus.i_bus_wr;

  // Address decode works on the request as it will be latched, so LATENCY==1 sees live inputs.
  assign off      = {1'b0, addr_d} - {1'b0, BASE_ADDR};
  assign in_range = (off < SPAN);
  assign widx     = off[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      mask_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      mask_q     <= mask_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (bus.i_bus_rd || bus.i_bus_wr) begin
          is_rd_d = bus.i_bus_rd;
          addr_d  = bus.i_bus_addr;
          wdat_d  = bus.i_bus_data;
          mask_d  = bus.i_bus_wrmask;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response flops are loaded on the edge entering RESP, so the pulse lasts exactly the RESP cycle.
  always_comb begin
    rd_valid_d = (state_d == RESP) && is_rd_d;
    wr_valid_d = (state_d == RESP) && !is_rd_d;
    rdata_d    = '0;
    if (rd_valid_d && in_range) rdata_d = mem_q[widx];
  end

  // Storage has no reset value; rst_n only blocks a commit on an edge seen during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_valid_d && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_d[b]) mem_q[widx][8*b +: 8] <= wdat_d[8*b +: 8];
      end
    end
  end

  assign bus.o_bus_rd_valid = rd_valid_q;
  assign bus.o_bus_wr_valid = wr_valid_q;
  assign bus.o_bus_data     = rdata_q;
endmodule
